// File: rtl/encoder_sample_sched.sv
// encoder_sample_sched: windowed round-robin capture of biased encoder counts into speed and position
module encoder_sample_sched #(
    parameter int N_CH     = 2,
    parameter int PERIOD   = 100000,
    parameter int CW       = 32,
    parameter int CNT_BIAS = 4192,
    localparam int RW = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int TW = $clog2(PERIOD)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [N_CH*CW-1:0] enc_cnt,
    output logic [N_CH-1:0]    enc_clr,
    output logic               sample_valid,
    input  logic               pos_clr,
    input  logic               rd_req,
    input  logic [RW-1:0]      rd_ch,
    output logic               rd_ack,
    output logic [CW-1:0]      rd_speed,
    output logic [CW-1:0]      rd_pos
);
    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
    state_t        state;
    logic [TW-1:0] tcnt;
    logic [RW-1:0] idx;
    logic [CW-1:0] speed [N_CH];
    logic [CW-1:0] pos [N_CH];
    logic [CW-1:0] delta;
    logic          accept;
    logic          rd_ok;
    assign delta  = enc_cnt[idx*CW +: CW] - CW'(CNT_BIAS);
    assign accept = (state != CAPTURE) && rd_req && !rd_ack;
    assign rd_ok  = int'(rd_ch) < N_CH;
    // Clear strobe for the channel being captured; suppressed while reset is asserted
    always_comb enc_clr = (state == CAPTURE && !reset) ? N_CH'(1) << idx : '0;
    // Window timer and capture sequencer; timer parks at 0 once idle with enable low
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt         <= '0;
            state        <= IDLE;
            idx          <= '0;
            sample_valid <= 1'b0;
        end else begin
            tcnt         <= (!enable && state != CAPTURE) ? '0 : (tcnt == TW'(PERIOD - 1)) ? '0 : tcnt + 1'b1;
            sample_valid <= 1'b0;
            case (state)
                IDLE: if (tcnt == TW'(PERIOD - 1)) begin
                    state <= CAPTURE;
                    idx   <= '0;
                end
                CAPTURE: if (idx == RW'(N_CH - 1)) begin
                    state        <= DONE;
                    sample_valid <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Per-channel speed/position update and host read port
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                speed[i] <= '0;
                pos[i]   <= '0;
            end
            rd_ack   <= 1'b0;
            rd_speed <= '0;
            rd_pos   <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++)
                if (pos_clr) pos[i] <= '0;
            if (state == CAPTURE) begin
                speed[idx] <= delta;
                pos[idx]   <= (pos_clr ? '0 : pos[idx]) + delta;
            end
            rd_ack <= accept;
            if (accept) begin
                rd_speed <= rd_ok ? speed[rd_ch] : '0;
                rd_pos   <= (rd_ok && !pos_clr) ? pos[rd_ch] : '0;
            end
        end
    end
endmodule

// File: tb/tb_encoder_sample_sched.sv
// tb_encoder_sample_sched: directed checks of window timing, capture math, pos_clr, reads and reset
module tb_encoder_sample_sched;
    localparam int N_CH = 2;
    localparam int PERIOD = 16;
    localparam int CW = 32;
    localparam int BIAS = 4192;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic pos_clr = 1'b0;
    logic rd_req = 1'b0;
    logic rd_ch = 1'b0;
    logic [N_CH*CW-1:0] enc_cnt = '0;
    logic [N_CH-1:0] enc_clr;
    logic sample_valid;
    logic rd_ack;
    logic [CW-1:0] rd_speed;
    logic [CW-1:0] rd_pos;
    int checks = 0;
    int failures = 0;

    encoder_sample_sched #(.N_CH(N_CH), .PERIOD(PERIOD), .CW(CW), .CNT_BIAS(BIAS)) dut (
        .clk(clk), .reset(reset), .enable(enable), .enc_cnt(enc_cnt), .enc_clr(enc_clr),
        .sample_valid(sample_valid), .pos_clr(pos_clr), .rd_req(rd_req), .rd_ch(rd_ch),
        .rd_ack(rd_ack), .rd_speed(rd_speed), .rd_pos(rd_pos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cnt(input logic [CW-1:0] d0, input logic [CW-1:0] d1);
        enc_cnt = {d1 + CW'(BIAS), d0 + CW'(BIAS)};
    endtask

    task automatic wait_for(input string tag, input logic on_sv, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(on_sv ? sample_valid : enc_clr[0]) && n < 100);
        chk(tag, 32'(n < 100), 32'd1);
    endtask

    task automatic rd(input logic ch, input logic [CW-1:0] es, input logic [CW-1:0] ep, input string tag);
        int n = 0;
        rd_req = 1'b1;
        rd_ch = ch;
        do begin
            tick();
            n++;
        end while (!rd_ack && n < 50);
        rd_req = 1'b0;
        chk({tag, "_ack"}, 32'(rd_ack), 32'd1);
        chk({tag, "_spd"}, rd_speed, es);
        chk({tag, "_pos"}, rd_pos, ep);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c0, c1, n0, n1, nsv, svk, ackk, extra;
        logic [CW-1:0] spd, ps;
        logic [5:0] pat;
        repeat (3) tick();
        chk("rst_clr", 32'(enc_clr), 32'd0);
        chk("rst_sv", 32'(sample_valid), 32'd0);
        chk("rst_ack", 32'(rd_ack), 32'd0);
        chk("rst_spd", rd_speed, 32'd0);
        chk("rst_pos", rd_pos, 32'd0);

        // T1: first window timing, ch1 +8
        set_cnt(32'd0, 32'd8);
        reset = 1'b0;
        enable = 1'b1;
        c0 = -1; c1 = -1; svk = -1; n0 = 0; n1 = 0; nsv = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (enc_clr[0]) begin n0++; if (c0 < 0) c0 = k; end
            if (enc_clr[1]) begin n1++; if (c1 < 0) c1 = k; end
            if (sample_valid) begin nsv++; if (svk < 0) svk = k; enable = 1'b0; end
        end
        chk("t1_clr0_cyc", 32'(c0), 32'd16);
        chk("t1_clr1_cyc", 32'(c1), 32'd17);
        chk("t1_sv_cyc", 32'(svk), 32'd18);
        chk("t1_pulses", 32'({n0[3:0], n1[3:0], nsv[3:0]}), 32'h111);
        rd(1'b0, 32'd0, 32'd0, "t1_ch0");
        rd(1'b1, 32'd8, 32'd8, "t1_ch1");

        // T2: three windows of -12 on ch0, then pos_clr during ch0 capture
        set_cnt(-12, 32'd0);
        enable = 1'b1;
        repeat (3) wait_for("t2_sv", 1'b1, n);
        enable = 1'b0;
        rd(1'b0, -12, -36, "t2_ch0");
        rd(1'b1, 32'd0, 32'd8, "t2_ch1");
        enable = 1'b1;
        wait_for("t2_c0", 1'b0, n);
        pos_clr = 1'b1;
        tick();
        pos_clr = 1'b0;
        wait_for("t2_sv_clr", 1'b1, n);
        enable = 1'b0;
        rd(1'b0, -12, -12, "t2_clr0");
        rd(1'b1, 32'd0, 32'd0, "t2_clr1");

        // T3: drive pos0 to 0x7FFFFFF0, then +32 wraps
        set_cnt(32'h7FFFFFFC, 32'd0);
        enable = 1'b1;
        wait_for("t3_sv_a", 1'b1, n);
        enable = 1'b0;
        rd(1'b0, 32'h7FFFFFFC, 32'h7FFFFFF0, "t3_pre");
        set_cnt(32'd32, 32'd0);
        enable = 1'b1;
        wait_for("t3_sv_b", 1'b1, n);
        enable = 1'b0;
        rd(1'b0, 32'd32, 32'h80000010, "t3_wrap");

        // T4: read raised at capture entry stalls until DONE
        set_cnt(32'd0, 32'd5);
        enable = 1'b1;
        wait_for("t4_c0", 1'b0, n);
        rd_req = 1'b1;
        rd_ch = 1'b1;
        svk = -1; ackk = -1; spd = '0; ps = '0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (sample_valid) begin svk = k; enable = 1'b0; end
            if (rd_ack && ackk < 0) begin ackk = k; spd = rd_speed; ps = rd_pos; rd_req = 1'b0; end
        end
        chk("t4_sv_cyc", 32'(svk), 32'd2);
        chk("t4_ack_cyc", 32'(ackk), 32'd3);
        chk("t4_spd", spd, 32'd5);
        chk("t4_pos", ps, 32'd5);
        rd_req = 1'b1;
        rd_ch = 1'b0;
        pat = '0;
        for (int k = 0; k < 6; k++) begin
            tick();
            pat = {pat[4:0], rd_ack};
        end
        rd_req = 1'b0;
        chk("t4_b2b", 32'(pat), 32'b101010);
        chk("t4_hold_pos", rd_pos, 32'h80000010);

        // T5: enable falls during ch0 capture
        set_cnt(32'd1, 32'd2);
        enable = 1'b1;
        wait_for("t5_c0", 1'b0, n);
        enable = 1'b0;
        c1 = -1; svk = -1; extra = 0;
        for (int k = 1; k <= 52; k++) begin
            tick();
            if (enc_clr[1] && c1 < 0) c1 = k;
            else if (enc_clr != '0) extra++;
            if (sample_valid) svk = k;
        end
        chk("t5_clr1_cyc", 32'(c1), 32'd1);
        chk("t5_sv_cyc", 32'(svk), 32'd2);
        chk("t5_quiet", 32'(extra), 32'd0);
        rd(1'b1, 32'd2, 32'd7, "t5_ch1");
        rd(1'b0, 32'd1, 32'h80000011, "t5_ch0");

        // T6: reset during capture
        enable = 1'b1;
        wait_for("t6_c0", 1'b0, n);
        chk("t6_start", 32'(n), 32'd16);
        reset = 1'b1;
        #1;
        chk("t6_clr_in_rst", 32'(enc_clr), 32'd0);
        tick();
        chk("t6_clr", 32'(enc_clr), 32'd0);
        chk("t6_sv", 32'(sample_valid), 32'd0);
        chk("t6_ack", 32'(rd_ack), 32'd0);
        chk("t6_spd", rd_speed, 32'd0);
        chk("t6_pos", rd_pos, 32'd0);
        reset = 1'b0;
        wait_for("t6_restart", 1'b0, n);
        chk("t6_restart_cyc", 32'(n), 32'd16);
        enable = 1'b0;
        wait_for("t6_sv", 1'b1, n);
        rd(1'b0, 32'd1, 32'd1, "t6_ch0");
        rd(1'b1, 32'd2, 32'd2, "t6_ch1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
